// File: rtl/mono_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mono_frame_buffer
// Purpose  : Ping-pong framer turning a mono sample strobe into AXI4-Stream
//            frames of FRAME_LEN samples with TLAST on the final sample.
// Options  : MONO_FRAME_BUFFER_DROP_COUNT_EN adds a saturating drop_count port.
// Revision : 1.0 - initial release
// ============================================================================
module mono_frame_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 256
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  mono_sample_valid,
    input  logic [DATA_WIDTH-1:0] mono_sample,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  frame_overrun
`ifdef MONO_FRAME_BUFFER_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    localparam int                 c_idx_w     = $clog2(FRAME_LEN);
    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(FRAME_LEN - 1);
    localparam logic [c_idx_w-1:0] c_first_idx = '0;

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_st_t;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM} rd_st_t;

    logic [DATA_WIDTH-1:0] r_mem [2][FRAME_LEN];
    bank_st_t              r_bank_st [2];
    logic                  r_wr_bank;
    logic [c_idx_w-1:0]    r_wr_idx;
    logic                  r_first_full;
    logic                  r_overrun;

    rd_st_t                r_rd_state;
    logic                  r_rd_bank;
    logic [c_idx_w-1:0]    r_rd_idx;
    logic [DATA_WIDTH-1:0] r_tdata;

    rd_st_t                w_nxt_state;
    logic                  w_nxt_rd_bank;
    logic [c_idx_w-1:0]    w_nxt_rd_idx;
    logic [DATA_WIDTH-1:0] w_nxt_tdata;

    logic w_rd_last, w_release, w_wr_stall, w_wr_en, w_drop, w_wr_done;
    logic w_other_wr, w_other_free, w_other_busy;

    assign w_rd_last    = (r_rd_idx == c_last_idx);
    assign w_release    = (r_rd_state == ST_STREAM) && M_AXIS_TREADY && w_rd_last;
    assign w_wr_stall   = (r_bank_st[r_wr_bank] == BANK_FULL);
    assign w_wr_en      = mono_sample_valid && !w_wr_stall;
    assign w_drop       = mono_sample_valid && w_wr_stall;
    assign w_wr_done    = w_wr_en && (r_wr_idx == c_last_idx);
    assign w_other_wr   = ~r_wr_bank;
    // A bank released on this very edge counts as free so back-to-back frames never drop.
    assign w_other_free = (r_bank_st[w_other_wr] == BANK_EMPTY) ||
                          (w_release && (r_rd_bank == w_other_wr));
    assign w_other_busy = (r_bank_st[w_other_wr] == BANK_FULL) &&
                          !(w_release && (r_rd_bank == w_other_wr));

    always_ff @(posedge M_AXIS_ACLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][r_wr_idx] <= mono_sample;
        end
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_wr_bank    <= 1'b0;
            r_wr_idx     <= '0;
            r_first_full <= 1'b0;
            r_overrun    <= 1'b0;
            r_bank_st[0] <= BANK_EMPTY;
            r_bank_st[1] <= BANK_EMPTY;
        end else begin
            r_overrun <= w_drop;
            if (w_wr_en) begin
                if (w_wr_done) begin
                    r_wr_idx <= '0;
                    if (w_other_free) begin
                        r_wr_bank <= w_other_wr;
                    end
                    if (!w_other_busy) begin
                        r_first_full <= r_wr_bank;
                    end
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end else if (w_wr_stall && w_release) begin
                r_wr_bank <= r_rd_bank;
            end
            for (int b = 0; b < 2; b++) begin
                if (w_release && (r_rd_bank == 1'(b))) begin
                    r_bank_st[b] <= BANK_EMPTY;
                end else if (w_wr_en && (r_wr_bank == 1'(b))) begin
                    r_bank_st[b] <= w_wr_done ? BANK_FULL : BANK_FILLING;
                end
            end
        end
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_rd_state <= ST_IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_idx   <= '0;
            r_tdata    <= '0;
        end else begin
            r_rd_state <= w_nxt_state;
            r_rd_bank  <= w_nxt_rd_bank;
            r_rd_idx   <= w_nxt_rd_idx;
            r_tdata    <= w_nxt_tdata;
        end
    end

    always_comb begin
        w_nxt_state   = r_rd_state;
        w_nxt_rd_bank = r_rd_bank;
        w_nxt_rd_idx  = r_rd_idx;
        w_nxt_tdata   = r_tdata;
        case (r_rd_state)
            ST_IDLE: begin
                if ((r_bank_st[0] == BANK_FULL) || (r_bank_st[1] == BANK_FULL)) begin
                    w_nxt_state = ST_LOAD;
                    if ((r_bank_st[0] == BANK_FULL) && (r_bank_st[1] == BANK_FULL)) begin
                        w_nxt_rd_bank = r_first_full;
                    end else begin
                        w_nxt_rd_bank = (r_bank_st[1] == BANK_FULL);
                    end
                end
            end
            ST_LOAD: begin
                w_nxt_tdata  = r_mem[r_rd_bank][c_first_idx];
                w_nxt_rd_idx = '0;
                w_nxt_state  = ST_STREAM;
            end
            ST_STREAM: begin
                if (M_AXIS_TREADY) begin
                    if (w_rd_last) begin
                        if (r_bank_st[~r_rd_bank] == BANK_FULL) begin
                            w_nxt_state   = ST_LOAD;
                            w_nxt_rd_bank = ~r_rd_bank;
                        end else begin
                            w_nxt_state = ST_IDLE;
                        end
                    end else begin
                        w_nxt_rd_idx = r_rd_idx + 1'b1;
                        w_nxt_tdata  = r_mem[r_rd_bank][r_rd_idx + 1'b1];
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TVALID = (r_rd_state == ST_STREAM);
    assign M_AXIS_TLAST  = (r_rd_state == ST_STREAM) && w_rd_last;
    assign frame_overrun = r_overrun;

`ifdef MONO_FRAME_BUFFER_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: doc/mono_frame_buffer.md
MONO_FRAME_BUFFER -- requirements
Module: mono_frame_buffer

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, the width of one mono sample and of TDATA.
REQ-002 The block SHALL expose parameter FRAME_LEN, default 256, the samples per output frame; legal values are powers of two from 4 to 1024.
REQ-003 The block SHALL expose port M_AXIS_ACLK, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL expose port M_AXIS_ARESETN, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL expose port mono_sample_valid, input, 1 bit, a single-cycle strobe that marks mono_sample as new.
REQ-006 The block SHALL expose port mono_sample, input, DATA_WIDTH bits, the mono sample from the packet-to-mono converter.
REQ-007 The block SHALL expose port M_AXIS_TDATA, output, DATA_WIDTH bits, the frame sample.
REQ-008 The block SHALL expose port M_AXIS_TVALID, output, 1 bit, which marks TDATA as valid.
REQ-009 The block SHALL expose port M_AXIS_TLAST, output, 1 bit, which marks the final sample of a frame.
REQ-010 The block SHALL expose port M_AXIS_TREADY, input, 1 bit, the downstream (FFT) ready signal.
REQ-011 The block SHALL expose port frame_overrun, output, 1 bit, a one-cycle pulse raised when a sample is dropped.

Function
REQ-012 Storage SHALL be two banks (ping-pong) of FRAME_LEN words, each bank flagged EMPTY, FILLING or FULL.
REQ-013 On mono_sample_valid, the sample SHALL be written at wr_idx of the current write bank and wr_idx SHALL increment.
REQ-014 When the write at wr_idx = FRAME_LEN-1 occurs, that bank SHALL become FULL, wr_idx SHALL wrap to 0, and writing SHALL move to the other bank if it is EMPTY.
REQ-015 If neither bank is EMPTY, each incoming valid sample SHALL be dropped with a frame_overrun pulse; writing SHALL resume at index 0 of the first bank released.
REQ-016 If a bank is released in the same cycle the other bank completes, the switch SHALL occur with no sample dropped.
REQ-017 The read FSM SHALL have states IDLE, LOAD and STREAM.
REQ-018 In IDLE, the FSM SHALL go to LOAD when any bank is FULL, choosing the oldest bank first.
REQ-019 In LOAD, the FSM SHALL register word 0 into TDATA with rd_idx=0, then go to STREAM.
REQ-020 In STREAM, TVALID SHALL be 1 and TLAST SHALL be (rd_idx = FRAME_LEN-1).
REQ-021 On TVALID&TREADY in STREAM, the next word SHALL be registered into TDATA in the same edge, giving one sample per cycle under continuous TREADY.
REQ-022 On the TLAST handshake, the bank SHALL become EMPTY and the FSM SHALL go to LOAD if the other bank is FULL, otherwise to IDLE.
REQ-023 While TVALID=1, TDATA and TLAST SHALL stay stable until the handshake (AXI4-Stream rule).
REQ-024 Latency SHALL be 2 cycles from the final write of a frame to TVALID=1 when the FSM is IDLE.
REQ-025 Samples SHALL pass through bit-exact, with no width change or sign manipulation.

Reset
REQ-026 Asserting reset SHALL drive TVALID=0, TLAST=0, TDATA=0 and frame_overrun=0, set both banks EMPTY, wr_idx=rd_idx=0, write bank 0, and FSM IDLE.
REQ-027 Reset mid-frame or mid-stream SHALL discard all buffered data; after release, the first frame SHALL begin with the next valid sample.
REQ-028 RAM contents SHALL NOT require reset.

Configuration
REQ-029 With the macro MONO_FRAME_BUFFER_DROP_COUNT_EN defined, the block SHALL add output drop_count, 16 bits, which counts dropped samples, saturates at 0xFFFF, and clears on reset.
REQ-030 Without MONO_FRAME_BUFFER_DROP_COUNT_EN, the drop_count port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (FRAME_LEN=4)
REQ-031 Samples 1..4 with TREADY=1 SHALL produce TDATA 1,2,3,4, with TLAST only on 4 and TVALID 2 cycles after the 4th write.
REQ-032 Samples 1..12 with TREADY=0 then TREADY=1 SHALL output 1..8 in two frames, drop 9..12 with four frame_overrun pulses, and give drop_count=4 when enabled.
REQ-033 TREADY toggling 1,0,1,0 during a frame SHALL hold TDATA/TLAST stable on stalled cycles, with the full frame delivered in order.
REQ-034 A release and a completion in the same cycle (frame B ends on A's TLAST handshake) SHALL drop no samples, with frame_overrun staying 0.
REQ-035 Reset asserted after sample 2 of a frame and mid-stream SHALL drop outputs to 0 immediately; samples 7..10 after release SHALL form the first frame.
